uart_rx_stream: RTL
===================

Name: uart_rx_stream

Overview:
- UART receiver for the mini16 SoC serial path. Deserialises 8N1 frames arriving on a uart_rxd line into bytes.
- Presents each byte on a valid/ready stream to the consumer: the master CPU I/O register block, or the bench-side program loader monitoring uart_txd.
- Provides mid-bit sampling, start-glitch rejection, framing-error detection and a sticky overrun flag.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- SCLK_HZ, 115200, serial baud rate in Hz.
- DIV (localparam), CLK_HZ/SCLK_HZ (integer division; 434 at defaults), clocks per bit. Width of the bit counter is clog2(DIV)+1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset. Asserted when 0.
- uart_rxd  in  1  serial input, idle high, asynchronous to clk.
- data  out  8  received byte; stable while valid=1.
- valid  out  1  byte available.
- ready  in  1  consumer accepts; transfer when valid&ready on a rising edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  sticky: a good byte arrived while valid=1 and the byte was not accepted.
- err_clear  in  1  synchronous clear of overrun.

Behaviour:
- Reset (reset=0, async): state=IDLE, bit counter=0, bit index=0, shift=0, data=0, valid=0, frame_err=0, overrun=0. Synchronizer flops preset to 1 (line idle).
- Input sync: 2-FF synchronizer on uart_rxd gives rxd_s. Falling-edge detect on rxd_s versus its previous value.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: on rxd_s falling edge, load counter=DIV/2-1 and go to START.
- START: decrement counter. At 0, sample rxd_s:
  - 0: load counter=DIV-1, bit index=0, go to DATA.
  - 1: glitch; return to IDLE with no output.
- DATA: at counter 0, shift rxd_s into shift[7] and right-shift (LSB first), reload DIV-1, increment index. After the 8th sample go to STOP.
- STOP: at counter 0, sample rxd_s:
  - 1 and (valid=0 or ready=1): data<=shift, valid<=1 next cycle. Go to IDLE.
  - 1 and valid=1 and ready=0: overrun<=1, data unchanged, new byte discarded. Go to IDLE.
  - 0: frame_err=1 for exactly one cycle, no valid. Go to BREAK.
- BREAK: wait until rxd_s=1, then go to IDLE. A line held low never produces bytes.
- Handshake:
  - valid clears on the cycle after valid&ready, unless a new byte loads in that same cycle, in which case valid stays 1 with the new data.
  - valid never drops without ready.
- err_clear=1 clears overrun the next cycle. If an overrun event coincides with err_clear, overrun ends 1 (set wins).
- Latency: the earliest valid=1 is 2 sync cycles + DIV/2 + 8*DIV + DIV + 1 clocks after the falling edge on uart_rxd.
- A new falling edge is only recognised from IDLE. Back-to-back frames work because STOP returns to IDLE at the stop-bit centre.
- Reset asserted mid-frame aborts immediately to reset values. A partial byte is never output.

Decomposition:
- Shared package/header: the state encodings (IDLE..BREAK, 3-bit) and the DIV computation function, reused by the transmit side (uart_tx).
- One natural sub-module: sync_2ff (parameterised width, reset value). The FSM, counter and output register stay in uart_rx_stream.

Test Plan:
All scenarios use CLK_HZ=16, SCLK_HZ=1, so DIV=16.
- Reset then idle line: hold reset=0 for 3 clocks, release, keep uart_rxd=1 for 200 clocks -> data=0, valid=0, frame_err=0, overrun=0 throughout.
- Single byte with ready=1: send 0xA5 (8N1, 16 clocks/bit) -> valid pulses 1 cycle with data=0xA5 at 2+8+128+16+1 clocks after the start edge; frame_err=0.
- Backpressure and overrun: ready=0, send 0x3C then 0xC3 -> valid=1, data stays 0x3C, overrun=1 after the second stop bit. Raise ready: valid drops after 1 cycle. Pulse err_clear: overrun=0.
- Framing error: send 0x55 with the stop bit driven 0, then hold low 40 clocks, then high -> frame_err is a 1-cycle pulse at the stop-bit centre, no valid. A following 0x12 is received correctly.
- Start glitch: drive uart_rxd low for 4 clocks, then high -> returns to IDLE, no valid, no frame_err. A subsequent 0xFF is received correctly.
- Async reset mid-frame: assert reset during bit 3 of 0x81 -> all outputs 0 within the same cycle. After release, a fresh 0x81 is received and nothing from the aborted frame appears.

Source files
------------

// File: rtl/uart_rx_stream_pkg.sv
// Shared UART definitions: receive/transmit FSM encodings and bit-period helper.
package uart_rx_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

  // Clocks per serial bit; integer division truncates toward the faster baud.
  function automatic int calc_div(input int clk_hz, input int sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

endpackage

// File: rtl/uart_rx_stream_if.sv
// Byte stream handshake: the receiver drives data/valid, the consumer drives ready.
interface uart_rx_stream_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_stream_sync_2ff.sv
// Two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver presenting bytes on a valid/ready stream, with start-glitch
// rejection, one-cycle framing-error pulse and sticky overrun.
module uart_rx_stream
  import uart_rx_stream_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int SCLK_HZ = 115200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               uart_rxd,
  uart_rx_stream_if.master   rx,
  output logic               frame_err,
  output logic               overrun,
  input  logic               err_clear
);
  localparam int DIV = calc_div(CLK_HZ, SCLK_HZ);
  localparam int CW  = $clog2(DIV) + 1;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  logic          rxd_s, rxd_prev_q;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d, data_q, data_d;
  logic          valid_q, valid_d, fe_q, fe_d, ovr_q, ovr_d;
  logic          tick, ld, ovr_set;

  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (uart_rxd),
    .q_o   (rxd_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_prev_q <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rxd_prev_q <= rxd_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ovr_q      <= ovr_d;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    fe_d    = 1'b0;
    ld      = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: if (!rxd_s && rxd_prev_q) begin
        cnt_d   = HALF;
        state_d = START;
      end
      START: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else if (!rxd_s) begin
          cnt_d   = FULL;
          idx_d   = '0;
          state_d = DATA;
        end else state_d = IDLE;
      end
      DATA: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          shift_d = {rxd_s, shift_q[7:1]};
          cnt_d   = FULL;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!tick) cnt_d = cnt_q - 1'b1;
        else begin
          state_d = rxd_s ? IDLE : BREAK;
          if (!rxd_s) fe_d = 1'b1;
          else if (!valid_q || rx.ready) begin
            data_d = shift_q;
            ld     = 1'b1;
          end else ovr_set = 1'b1;
        end
      end
      BREAK: if (rxd_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A byte loading in the same cycle as a transfer keeps valid high.
    valid_d = ld | (valid_q & ~rx.ready);
    ovr_d   = ovr_set | (ovr_q & ~err_clear);
  end

  assign rx.data   = data_q;
  assign rx.valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
endmodule
